// File: rtl/led_output_pkg.sv
// rtl/led_output_pkg.sv - shared defaults and light-code constants for the LED output stage
package led_output_pkg;

  localparam int DEFAULT_N_CH      = 6;
  localparam int DEFAULT_PWM_BITS  = 8;
  localparam int DEFAULT_BLINK_DIV = 16;

  // Per-approach light codes; callers concatenate two of them to form lit.
  localparam logic [2:0] LIT_RED    = 3'b100;
  localparam logic [2:0] LIT_YELLOW = 3'b010;
  localparam logic [2:0] LIT_GREEN  = 3'b001;

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - free-running PWM counter, period-end tick and blink phase generator
module pwm_timebase
  import led_output_pkg::*;
#(
  parameter int PWM_BITS  = DEFAULT_PWM_BITS,
  parameter int BLINK_DIV = DEFAULT_BLINK_DIV
) (
  input  logic                clk,
  input  logic                n_reset,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                period_tick,
  output logic                blink_phase
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;

  assign period_tick = &pwm_cnt;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      // Blink timebase advances once per PWM period, aligned with shadow capture.
      if (period_tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_output.sv
// rtl/led_output.sv - period-synchronous shadowed LED driver with global PWM and per-channel blink
module led_output
  import led_output_pkg::*;
#(
  parameter int N_CH      = DEFAULT_N_CH,
  parameter int PWM_BITS  = DEFAULT_PWM_BITS,
  parameter int BLINK_DIV = DEFAULT_BLINK_DIV
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [N_CH-1:0]     lit,
  input  logic [N_CH-1:0]     blink_en,
  input  logic [PWM_BITS-1:0] duty,
  output logic [N_CH-1:0]     n_led,
  output logic                period_tick
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                blink_phase;
  logic [N_CH-1:0]     lit_q;
  logic [N_CH-1:0]     blink_q;
  logic [PWM_BITS-1:0] duty_q;
  logic                pwm_on;
  logic [N_CH-1:0]     on;

  pwm_timebase #(
    .PWM_BITS  (PWM_BITS),
    .BLINK_DIV (BLINK_DIV)
  ) u_timebase (
    .clk         (clk),
    .n_reset     (n_reset),
    .pwm_cnt     (pwm_cnt),
    .period_tick (period_tick),
    .blink_phase (blink_phase)
  );

  // All-ones duty is a true 100%; a plain compare would drop the last slot.
  always_comb begin
    pwm_on = 1'b0;
    on     = '0;
    if (&duty_q) begin
      pwm_on = 1'b1;
    end else begin
      pwm_on = (pwm_cnt < duty_q);
    end
    on = lit_q & (~blink_q | {N_CH{blink_phase}}) & {N_CH{pwm_on}};
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lit_q   <= '0;
      blink_q <= '0;
      duty_q  <= '0;
      n_led   <= '1;
    end else begin
      if (period_tick) begin
        lit_q   <= lit;
        blink_q <= blink_en;
        duty_q  <= duty;
      end
      n_led <= ~on;
    end
  end

endmodule

// File: tb/tb_led_output.sv
// tb/tb_led_output.sv - scoreboard bench: per-period n_led vectors queued by stimulus, checked by monitor
module tb_led_output;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic [5:0] lit = '0;
  logic [5:0] blink_en = '0;
  logic [3:0] duty = '0;
  logic [5:0] n_led;
  logic       period_tick;

  int tests = 0;
  int fails = 0;
  int cur = 0;

  typedef struct {
    int                per;
    string             name;
    logic [15:0][5:0]  vec;
  } exp_t;

  exp_t q[$];

  led_output #(.N_CH(6), .PWM_BITS(4), .BLINK_DIV(2)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .lit         (lit),
    .blink_en    (blink_en),
    .duty        (duty),
    .n_led       (n_led),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  // Index j = pwm_cnt while sampled; pos 0 still shows the previous period's last slot.
  function automatic logic [15:0][5:0] gen(logic [5:0] first, logic [5:0] rest, logic [3:0] d);
    logic [15:0][5:0] v;
    logic [5:0]       o;
    for (int j = 0; j < 16; j++) begin
      if (j == 0) o = (d == 4'hF) ? first : 6'h00;
      else        o = (d == 4'hF || j <= int'(d)) ? rest : 6'h00;
      v[j] = ~o;
    end
    return v;
  endfunction

  task automatic push(input int per, input string name, input logic [5:0] first,
                      input logic [5:0] rest, input logic [3:0] d);
    exp_t e;
    e.per  = per;
    e.name = name;
    e.vec  = gen(first, rest, d);
    q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!period_tick && n < 40);
    if (!period_tick) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: no period_tick within %0d cycles, expected one within 16", n);
    end
    cur++;
  endtask

  task automatic goto(input int k);
    while (cur < k) wait_tick();
  endtask

  task automatic release_and_time(input string name);
    int n;
    n_reset = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!period_tick && n < 40);
    tests++;
    if (n != 15) begin
      fails++;
      $display("FAIL %s: first period_tick after %0d cycles, expected 15", name, n);
    end
    cur = 0;
  endtask

  // Monitor: gathers one period of n_led samples and compares at each period_tick.
  int               mper = 0;
  int               mpos = 1;
  logic [15:0][5:0] cap;

  always @(negedge clk) begin
    exp_t e;
    if (!n_reset) begin
      mper = 0;
      mpos = 1;
    end else begin
      cap[mpos] = n_led;
      if (period_tick) begin
        while (q.size() > 0 && q[0].per < mper) begin
          e = q.pop_front();
          tests++;
          fails++;
          $display("FAIL %s: period %0d not observed, now at %0d", e.name, e.per, mper);
        end
        if (q.size() > 0 && q[0].per == mper) begin
          e = q.pop_front();
          tests++;
          if (cap !== e.vec) begin
            fails++;
            $display("FAIL %s: period %0d got %h expected %h", e.name, mper, cap, e.vec);
          end
        end
        mper++;
        mpos = 0;
      end else if (mpos < 15) begin
        mpos++;
      end
    end
  end

  initial begin
    #1;
    n_reset = 1'b0;
    lit     = 6'h3F;
    duty    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_n_led", n_led, 6'h3F);
      chk("reset_tick", {5'b0, period_tick}, 6'h00);
    end
    release_and_time("first_tick");

    lit = 6'h21; blink_en = 6'h00; duty = 4'hF;
    push(1, "full_on_first", 6'h00, 6'h21, 4'hF);
    push(2, "full_on_steady", 6'h21, 6'h21, 4'hF);
    goto(2);

    lit = 6'h01; duty = 4'd4;
    push(4, "duty4_a", 6'h01, 6'h01, 4'd4);
    push(5, "duty4_b", 6'h01, 6'h01, 4'd4);
    goto(5);

    duty = 4'd0;
    push(6, "duty0_a", 6'h01, 6'h01, 4'd0);
    push(7, "duty0_b", 6'h01, 6'h01, 4'd0);
    goto(7);

    duty = 4'hF;
    push(8, "mid_pre", 6'h00, 6'h01, 4'hF);
    goto(8);
    push(9, "mid_hold", 6'h01, 6'h01, 4'hF);
    push(10, "mid_switch", 6'h01, 6'h02, 4'hF);
    push(11, "mid_after", 6'h02, 6'h02, 4'hF);
    for (int i = 0; i < 8; i++) step();
    lit = 6'h02;
    goto(11);

    lit = 6'h05; blink_en = 6'h04;
    push(12, "blink_on_a", 6'h02, 6'h05, 4'hF);
    push(13, "blink_on_b", 6'h05, 6'h05, 4'hF);
    push(14, "blink_off_a", 6'h05, 6'h01, 4'hF);
    push(15, "blink_off_b", 6'h01, 6'h01, 4'hF);
    push(16, "blink_on_c", 6'h01, 6'h05, 4'hF);
    goto(16);

    for (int i = 0; i < 10; i++) step();
    n_reset = 1'b0;
    #1;
    chk("midreset_n_led", n_led, 6'h3F);
    chk("midreset_tick", {5'b0, period_tick}, 6'h00);
    for (int i = 0; i < 3; i++) step();
    chk("midreset_hold", n_led, 6'h3F);
    push(1, "post_reset_on", 6'h00, 6'h05, 4'hF);
    push(2, "post_reset_off", 6'h05, 6'h01, 4'hF);
    push(3, "post_reset_off_b", 6'h01, 6'h01, 4'hF);
    release_and_time("restart_tick");
    goto(4);
    step();

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
